serial_bus_master: RTL and testbench

//  Bus initiator driven by a byte stream: parses command frames from the usb_serial rx

---
 rtl/serial_bus_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_serial_bus_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// ---------------------------------------------------------------------------
// serial_bus_master
//
// Host-side bus initiator. A byte stream arriving on the serial rx interface
// is parsed into command frames. Each frame becomes exactly one 32-bit
// memory-bus transaction, and the result goes back out on the tx interface.
//
// Frame layout (bytes in arrival order):
//   CMD, A0, A1, A2, A3                  read  (CMD[7:4] = 4'h1)
//   CMD, A0, A1, A2, A3, D0, D1, D2, D3  write (CMD[7:4] = 4'h2, CMD[3:0] = mask)
// Address and data are little-endian. Any other CMD[7:4] is answered with
// ERR_BYTE.
//
// Replies:
//   read   -> four bytes of read data, least significant byte first
//   write  -> ACK_BYTE
//   error  -> ERR_BYTE (bad opcode or responder timeout)
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   rx_strobe/rx_data one-cycle byte strobe from the serial receiver
//   tx_ready          serial transmitter can accept a byte
//   tx_strobe/tx_data one-cycle byte strobe to the serial transmitter
//   address_out       bus address
//   sel_out           bus select, held until ready_in
//   read_out          1 = read, 0 = write (meaningful while sel_out)
//   write_mask_out    byte lanes to write (0 for reads)
//   write_value_out   write data
//   read_value_in     read data from the responder
//   ready_in          responder completes the transaction
//   busy              controller is not idle
//   overrun           sticky: an rx byte arrived while it could not be used
// ---------------------------------------------------------------------------
module serial_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_strobe,
  output logic [7:0]  tx_data,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned        WAIT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_ERR
  } state_t;

  state_t            r_state;
  logic              r_is_write;
  logic [3:0]        r_mask;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_sel;
  logic              r_read;
  logic              r_tx_strobe;
  logic [7:0]        r_tx_data;
  logic              r_overrun;

  // Bytes that arrive while a transaction is in flight or a reply is being
  // sent cannot be buffered; they are dropped and flagged.
  logic w_rx_drop;
  // A reply byte may be launched only when the transmitter is ready and the
  // previous cycle was not itself a strobe, so strobes are never adjacent.
  logic w_tx_go;

  assign w_rx_drop = rx_strobe &&
                     ((r_state == S_BUS) || (r_state == S_RESP) || (r_state == S_ERR));
  assign w_tx_go   = tx_ready && !r_tx_strobe;

  // Replace byte lane n of a little-endian word.
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  n,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (n)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Extract byte lane n of a little-endian word.
  function automatic logic [7:0] get_byte(input logic [31:0] w,
                                          input logic [1:0]  n);
    logic [7:0] r;
    case (n)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_mask      <= 4'h0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_cnt       <= 2'd0;
      r_wait      <= '0;
      r_sel       <= 1'b0;
      r_read      <= 1'b0;
      r_tx_strobe <= 1'b0;
      r_tx_data   <= 8'h00;
      r_overrun   <= 1'b0;
    end else begin
      // tx_strobe is a single-cycle pulse unless re-armed below.
      r_tx_strobe <= 1'b0;

      if (w_rx_drop) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_strobe) begin
            r_cnt <= 2'd0;
            case (rx_data[7:4])
              4'h1: begin
                r_is_write <= 1'b0;
                r_mask     <= 4'h0;
                r_state    <= S_ADDR;
              end
              4'h2: begin
                r_is_write <= 1'b1;
                r_mask     <= rx_data[3:0];
                r_state    <= S_ADDR;
              end
              default: begin
                r_state <= S_ERR;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_strobe) begin
            r_addr <= put_byte(r_addr, r_cnt, rx_data);
            // r_cnt wraps to 0 after the fourth byte, ready for DATA/RESP.
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                // Select goes out together with the state change so the
                // bus request is visible in the first BUS cycle.
                r_state <= S_BUS;
                r_sel   <= 1'b1;
                r_read  <= 1'b1;
                r_wait  <= '0;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_strobe) begin
            r_wdata <= put_byte(r_wdata, r_cnt, rx_data);
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_BUS;
              r_sel   <= 1'b1;
              r_read  <= 1'b0;
              r_wait  <= '0;
            end
          end
        end

        S_BUS: begin
          // r_sel is always high in this state; completion or abort both
          // drop it on the same edge that leaves the state.
          if (ready_in) begin
            r_rdata <= read_value_in;
            r_sel   <= 1'b0;
            r_read  <= 1'b0;
            r_cnt   <= 2'd0;
            r_state <= S_RESP;
          end else if (r_wait == WAIT_LAST) begin
            r_sel   <= 1'b0;
            r_read  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_RESP: begin
          if (w_tx_go) begin
            r_tx_strobe <= 1'b1;
            if (r_is_write) begin
              r_tx_data <= ACK_BYTE;
              r_state   <= S_IDLE;
            end else begin
              r_tx_data <= get_byte(r_rdata, r_cnt);
              r_cnt     <= r_cnt + 2'd1;
              if (r_cnt == 2'd3) begin
                r_state <= S_IDLE;
              end
            end
          end
        end

        S_ERR: begin
          if (w_tx_go) begin
            r_tx_strobe <= 1'b1;
            r_tx_data   <= ERR_BYTE;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_strobe       = r_tx_strobe;
  assign tx_data         = r_tx_data;
  assign address_out     = r_addr;
  assign sel_out         = r_sel;
  assign read_out        = r_read;
  assign write_mask_out  = r_mask;
  assign write_value_out = r_wdata;
  assign busy            = (r_state != S_IDLE);
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_serial_bus_master.sv
// ---------------------------------------------------------------------------
// tb_serial_bus_master
//
// Drives command frames into serial_bus_master, plays a memory responder with
// a programmable ready delay, and compares observed bus transactions and tx
// bytes against expectations derived from the frame contents alone.
// ---------------------------------------------------------------------------
module tb_serial_bus_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_strobe;
  logic [7:0]  tx_data;
  logic [31:0] address_out;
  logic        sel_out;
  logic        read_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        busy;
  logic        overrun;

  serial_bus_master #(
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE      (8'hAA),
    .ERR_BYTE      (8'hEE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_strobe      (rx_strobe),
    .rx_data        (rx_data),
    .tx_ready       (tx_ready),
    .tx_strobe      (tx_strobe),
    .tx_data        (tx_data),
    .address_out    (address_out),
    .sel_out        (sel_out),
    .read_out       (read_out),
    .write_mask_out (write_mask_out),
    .write_value_out(write_value_out),
    .read_value_in  (read_value_in),
    .ready_in       (ready_in),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Responder / tx-ready controls set by the stimulus.
  int          rsp_delay = 0;      // sel cycles before ready; -1 = never
  logic [31:0] rsp_data  = 32'h0;
  bit          rand_txr  = 1'b0;
  logic        txr_force = 1'b1;

  typedef struct packed {
    logic [31:0] a;
    logic        rd;
    logic [3:0]  m;
    logic [31:0] v;
  } txn_t;

  txn_t       bus_q[$];
  int         run_q[$];
  int         to_q[$];
  logic [7:0] tx_q[$];
  int         bb_viol   = 0;
  int         rdy_viol  = 0;
  int         stab_viol = 0;

  // Responder: raises ready_in in the (rsp_delay+1)-th select cycle and only
  // presents valid read data in that cycle.
  int sel_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (sel_out) begin
      ready_in      = (rsp_delay >= 0) && (sel_cnt == rsp_delay);
      read_value_in = ready_in ? rsp_data : $urandom();
      sel_cnt++;
    end else begin
      ready_in      = 1'b0;
      read_value_in = $urandom();
      sel_cnt       = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ready = rand_txr ? 1'($urandom_range(0, 1)) : txr_force;
  end

  // Monitor, sampled mid-cycle.
  txn_t mon_cur;
  txn_t mon_snap;
  int   mon_run  = 0;
  logic prev_txs = 1'b0;
  logic prev_txr = 1'b0;
  always @(negedge clk) begin
    if (tx_strobe) begin
      tx_q.push_back(tx_data);
      if (prev_txs) bb_viol++;
      if (!prev_txr) rdy_viol++;
    end
    prev_txs = tx_strobe;
    prev_txr = tx_ready;
    mon_cur = '{a: address_out, rd: read_out, m: write_mask_out, v: write_value_out};
    if (sel_out) begin
      if (mon_run == 0) mon_snap = mon_cur;
      else if (mon_cur != mon_snap) stab_viol++;
      mon_run++;
      if (ready_in) begin
        bus_q.push_back(mon_snap);
        run_q.push_back(mon_run);
        mon_run = 0;
      end
    end else if (mon_run != 0) begin
      to_q.push_back(mon_run);
      mon_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  // One complete frame with expectations computed from its contents.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int dly, input bit ovr, input bit thr);
    logic [7:0] bytes[$];
    logic [7:0] exp_tx[$];
    bit         valid;
    bit         wr;
    int         n;
    valid = (cmd[7:4] == 4'h1) || (cmd[7:4] == 4'h2);
    wr    = (cmd[7:4] == 4'h2);
    bus_q.delete(); run_q.delete(); to_q.delete(); tx_q.delete();
    rsp_delay = dly;
    rsp_data  = rd;
    if (thr) begin
      rand_txr  = 1'b0;
      txr_force = 1'b0;
    end

    bytes.push_back(cmd);
    if (valid) begin
      for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) bytes.push_back(wd[8*i +: 8]);
    end
    if (!valid || dly < 0)  exp_tx.push_back(8'hEE);
    else if (wr)            exp_tx.push_back(8'hAA);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);

    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i]);
      if (i == 0) chk("busy_after_cmd", 64'(busy), 64'(1));
      if (i != bytes.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end

    if (ovr) begin
      n = 0;
      while (!sel_out && n < 50) begin tick(); n++; end
      send_byte(8'h5A);
      chk("overrun_set", 64'(overrun), 64'(1));
    end

    if (thr) begin
      n = 0;
      while (bus_q.size() == 0 && n < 200) begin tick(); n++; end
      repeat (20) tick();
      chk("throttle_no_tx", 64'(tx_q.size()), 64'(0));
      chk("throttle_busy", 64'(busy), 64'(1));
      txr_force = 1'b1;
    end

    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk("busy_clear", 64'(busy), 64'(0));
    tick(); tick();

    chk("bus_count", 64'(bus_q.size()), 64'((valid && dly >= 0) ? 1 : 0));
    if (valid && dly >= 0 && bus_q.size() == 1) begin
      chk("bus_addr", 64'(bus_q[0].a), 64'(addr));
      chk("bus_read", 64'(bus_q[0].rd), 64'(!wr));
      chk("bus_mask", 64'(bus_q[0].m), 64'(wr ? cmd[3:0] : 4'h0));
      if (wr) chk("bus_wdata", 64'(bus_q[0].v), 64'(wd));
      chk("sel_cycles", 64'(run_q[0]), 64'(dly + 1));
    end
    if (valid && dly < 0) begin
      chk("timeout_runs", 64'(to_q.size()), 64'(1));
      if (to_q.size() == 1) chk("timeout_len", 64'(to_q[0]), 64'(TO));
    end
    chk("tx_count", 64'(tx_q.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_q.size()) chk($sformatf("tx_byte%0d", i), 64'(tx_q[i]), 64'(exp_tx[i]));
    chk("tx_rules", 64'(bb_viol + rdy_viol), 64'(0));
    chk("sel_stable", 64'(stab_viol), 64'(0));
    if (thr) rand_txr = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_sel"},  64'(sel_out),   64'(0));
    chk({tag, "_busy"}, 64'(busy),      64'(0));
    chk({tag, "_txs"},  64'(tx_strobe), 64'(0));
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] bad_hi;
    logic [7:0] cmd;
    int         sel;
    int         n;

    reset     = 1'b1;
    rx_strobe = 1'b0;
    rx_data   = 8'h00;
    repeat (3) tick();
    chk("rst_sel",   64'(sel_out),         64'(0));
    chk("rst_txs",   64'(tx_strobe),       64'(0));
    chk("rst_txd",   64'(tx_data),         64'(0));
    chk("rst_busy",  64'(busy),            64'(0));
    chk("rst_ovr",   64'(overrun),         64'(0));
    chk("rst_addr",  64'(address_out),     64'(0));
    chk("rst_read",  64'(read_out),        64'(0));
    chk("rst_mask",  64'(write_mask_out),  64'(0));
    chk("rst_wval",  64'(write_value_out), 64'(0));
    reset = 1'b0;
    tick();

    do_frame(8'h11, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    do_frame(8'h2F, 32'h0000_0008, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0);
    do_frame(8'h55, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_frame(8'h13, $urandom(), 32'h0, $urandom(), 2, 1'b0, 1'b0);
    do_frame(8'h10, $urandom(), 32'h0, $urandom(), -1, 1'b0, 1'b0);
    chk("ovr_still_clear", 64'(overrun), 64'(0));

    rand_txr = 1'b1;
    do_frame(8'h12, $urandom(), 32'h0, $urandom(), 5, 1'b1, 1'b1);

    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        cmd = {4'h1, 4'($urandom_range(0, 15))};
      end else if (sel < 8) begin
        cmd = {4'h2, 4'($urandom_range(0, 15))};
      end else begin
        do bad_hi = 4'($urandom_range(0, 15)); while (bad_hi == 4'h1 || bad_hi == 4'h2);
        cmd = {bad_hi, 4'($urandom_range(0, 15))};
      end
      do_frame(cmd, $urandom(), $urandom(), $urandom(),
               (sel == 9) ? -1 : $urandom_range(0, 6), 1'b0, 1'b0);
    end

    // Reset in the middle of the data phase of a write.
    send_byte(8'h2C);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    async_reset("rst_data");
    do_frame(8'h23, $urandom(), $urandom(), 32'h0, 1, 1'b0, 1'b0);

    // Reset while a bus cycle is waiting for ready.
    rsp_delay = -1;
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
    n = 0;
    while (!sel_out && n < 50) begin tick(); n++; end
    chk("bus_sel_seen", 64'(sel_out), 64'(1));
    tick(); tick(); tick();
    async_reset("rst_bus");
    chk("rst_bus_ovr",  64'(overrun),  64'(0));
    chk("rst_bus_read", 64'(read_out), 64'(0));
    do_frame(8'h1A, $urandom(), 32'h0, $urandom(), 4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
